microsequencer: RTL and testbench

Microsequencer stage sitting directly upstream of the control-logic decoder. It holds the instruction register, the T-state counter and the program counter, and forms the microcode ROM address {opcode, tstate}. The ROM word it selects is forwarded, unmodified, as the 16-bit microinstruction that the control decoder turns into bus-enable, register-load, ALU and jump strobes. Decoded strobes (II, RT, PP, JMP) come back from the control stage and update the sequencer state on the next clock edge.

---
 rtl/microsequencer_if.sv | 34 +++
 rtl/microsequencer.sv | 58 +++++
 tb/tb_microsequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/microsequencer_if.sv
// Sequencer <-> control/ROM connection: data bus, decoded strobes, ROM port and
// the sequencer's architectural state.
interface microsequencer_if #(
  parameter int OPCODE_W = 8,
  parameter int TSTATE_W = 3,
  parameter int UINSTR_W = 16
);
  // Strobes are level-sampled, single-cycle commands with no valid/ready
  // handshake: whatever is high at a rising edge is applied at that edge,
  // and halt gates every strobe.
  logic [15:0]                  bus_in;
  logic                         II;
  logic                         RT;
  logic                         PP;
  logic                         JMP;
  logic                         halt;
  logic [UINSTR_W-1:0]          rom_data;
  logic [OPCODE_W+TSTATE_W-1:0] rom_addr;
  logic [UINSTR_W-1:0]          uinstr;
  logic [OPCODE_W-1:0]          opcode;
  logic [TSTATE_W-1:0]          tstate;
  logic [15:0]                  pc;
  logic [15:0]                  instr_count;

  modport master (
    output bus_in, II, RT, PP, JMP, halt, rom_data,
    input  rom_addr, uinstr, opcode, tstate, pc, instr_count
  );

  modport slave (
    input  bus_in, II, RT, PP, JMP, halt, rom_data,
    output rom_addr, uinstr, opcode, tstate, pc, instr_count
  );
endinterface

// File: rtl/microsequencer.sv
// Microsequencer: instruction register, T-state counter and program counter
// forming the microcode ROM address {opcode, tstate}.
module microsequencer #(
  parameter int OPCODE_W = 8,
  parameter int TSTATE_W = 3,
  parameter int UINSTR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  microsequencer_if.slave   sif
);

  localparam logic [TSTATE_W-1:0] TS_LAST = '1;

  logic [OPCODE_W-1:0] opcode_q;
  logic [TSTATE_W-1:0] tstate_q;
  logic [15:0]         pc_q;
  logic [15:0]         count_q;

  logic                ts_last;
  logic                instr_done;
  logic [TSTATE_W-1:0] tstate_next;

  // An instruction ends whenever the step counter returns to zero,
  // either through RT (even at step 0) or the natural wrap.
  always_comb begin
    ts_last     = (tstate_q == TS_LAST);
    instr_done  = sif.RT || ts_last;
    tstate_next = instr_done ? '0 : tstate_q + TSTATE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q <= '0;
      tstate_q <= '0;
      pc_q     <= '0;
      count_q  <= '0;
    end else if (!sif.halt) begin
      tstate_q <= tstate_next;
      if (sif.II)
        opcode_q <= sif.bus_in[15 -: OPCODE_W];
      if (sif.JMP)
        pc_q <= sif.bus_in;
      else if (sif.PP)
        pc_q <= pc_q + 16'd1;
      if (instr_done)
        count_q <= count_q + 16'd1;
    end
  end

  assign sif.rom_addr    = {opcode_q, tstate_q};
  assign sif.uinstr      = reset ? '0 : sif.rom_data;
  assign sif.opcode      = opcode_q;
  assign sif.tstate      = tstate_q;
  assign sif.pc          = pc_q;
  assign sif.instr_count = count_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed vector bench for the microsequencer with a pattern-generating ROM.
module tb_microsequencer;

  logic clk;
  logic reset;

  microsequencer_if #(.OPCODE_W(8), .TSTATE_W(3), .UINSTR_W(16)) sif ();

  microsequencer #(.OPCODE_W(8), .TSTATE_W(3), .UINSTR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [10:0] addr);
    return {addr, 5'h16} ^ 16'h0F0F;
  endfunction

  assign sif.rom_data = rom_f(sif.rom_addr);

  typedef struct {
    logic        rst;
    logic        halt;
    logic        ii;
    logic        rt;
    logic        pp;
    logic        jmp;
    logic [15:0] bus;
    logic [15:0] e_pc;
    logic [7:0]  e_op;
    logic [2:0]  e_ts;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic rst, input logic halt, input logic ii,
                              input logic rt, input logic pp, input logic jmp,
                              input logic [15:0] bus, input logic [15:0] e_pc,
                              input logic [7:0] e_op, input logic [2:0] e_ts,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.halt = halt; v.ii = ii; v.rt = rt; v.pp = pp; v.jmp = jmp;
    v.bus = bus; v.e_pc = e_pc; v.e_op = e_op; v.e_ts = e_ts; v.e_cnt = e_cnt;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic halt, input logic ii, input logic rt,
                       input logic pp, input logic jmp, input logic [15:0] bus);
    reset      = rst;
    sif.halt   = halt;
    sif.II     = ii;
    sif.RT     = rt;
    sif.PP     = pp;
    sif.JMP    = jmp;
    sif.bus_in = bus;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int idx, input vec_t v);
    logic [15:0] e_u;
    e_u = v.rst ? 16'h0000 : rom_f({v.e_op, v.e_ts});
    check($sformatf("v%0d pc", idx),       {16'h0, sif.pc},          {16'h0, v.e_pc});
    check($sformatf("v%0d opcode", idx),   {24'h0, sif.opcode},      {24'h0, v.e_op});
    check($sformatf("v%0d tstate", idx),   {29'h0, sif.tstate},      {29'h0, v.e_ts});
    check($sformatf("v%0d count", idx),    {16'h0, sif.instr_count}, {16'h0, v.e_cnt});
    check($sformatf("v%0d rom_addr", idx), {21'h0, sif.rom_addr},    {21'h0, v.e_op, v.e_ts});
    check($sformatf("v%0d uinstr", idx),   {16'h0, sif.uinstr},      {16'h0, e_u});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hABCD);

    // reset with every strobe high, then reset together with halt
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 16'hABCD, 16'h0000, 8'h00, 3'd0, 16'd0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 16'hABCD, 16'h0000, 8'h00, 3'd0, 16'd0));
    // free run 9 clocks: wrap 7 -> 0 counts one instruction
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 3'(k % 8),
                        (k >= 8) ? 16'd1 : 16'd0));
    // fetch of opcode 0x5A with PC increment, then early RT at step 3
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 16'h5A00, 16'h0001, 8'h5A, 3'd2, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 8'h5A, 3'd3, 16'd1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0001, 8'h5A, 3'd0, 16'd2));
    // jumps, JMP over PP, PC wrap
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0010, 16'h0010, 8'h5A, 3'd1, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 16'h1234, 16'h1234, 8'h5A, 3'd2, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 8'h5A, 3'd3, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 8'h5A, 3'd4, 16'd2));
    // halt with all strobes for 3 cycles, then resume from held step
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 1, 1, 1, 1, 16'hBEEF, 16'h0000, 8'h5A, 3'd4, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h5A, 3'd5, 16'd2));
    // reset at step 5 with halt and JMP
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 16'h7777, 16'h0000, 8'h00, 3'd0, 16'd0));
    // RT at step 0 still counts; then all strobes at once
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 3'd0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 3'd0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 16'hC3A5, 16'hC3A5, 8'hC3, 3'd0, 16'd3));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].halt, vecs[i].ii, vecs[i].rt, vecs[i].pp, vecs[i].jmp,
            vecs[i].bus);
      tick();
      check_state(i, vecs[i]);
    end

    // full 8-step instruction with PP every step: steps 1..7 then wrap to 0
    for (int k = 1; k <= 8; k++)
      exp_q.push_back(16'(k % 8));
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] e;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      tick();
      e = exp_q.pop_front();
      check($sformatf("run8 tstate %0d", k), {29'h0, sif.tstate}, {16'h0, e});
      check($sformatf("run8 pc %0d", k), {16'h0, sif.pc}, 32'hC3A5 + 32'(k));
    end
    check("run8 count", {16'h0, sif.instr_count}, 32'd4);
    check("run8 opcode", {24'h0, sif.opcode}, 32'hC3);

    // combinational uinstr gating by reset within the same cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("uinstr gated by reset", {16'h0, sif.uinstr}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("uinstr ungated", {16'h0, sif.uinstr}, {16'h0, rom_f({8'hC3, 3'd0})});

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
